// File: rtl/sudoku_puzzle_loader.sv
// Port-B writer that loads a 4x4 starting puzzle into the board RAM, reads every row back to verify it,
// and reloads on a verify mismatch. Port B is handed to the checker whenever portOwn is low.
module sudoku_puzzle_loader #(
    parameter int ADDR_W    = 2,
    parameter int ROW_W     = 20,
    parameter int READ_LAT  = 1,
    parameter int MAX_RETRY = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              newGame,
    input  logic [1:0]        puzzleSel,
    output logic [ADDR_W-1:0] RamAddr,
    output logic [ROW_W-1:0]  RamDat,
    output logic              RamWriteBit,
    input  logic [ROW_W-1:0]  RamQ,
    output logic              portOwn,
    output logic              loadDone,
    output logic              loadError,
    output logic [1:0]        retryCount
);

    typedef enum logic [2:0] {IDLE, WRITE, VADDR, VWAIT, DONE, ERROR} stateT;

    localparam logic [7:0] WAIT_LAST = 8'(READ_LAT - 1);

    stateT      state;
    logic [1:0] sel;
    logic [1:0] row;
    logic [7:0] waitCnt;

    // Givens of puzzle 0 as one nibble per cell (cell 0 lowest, 0 = empty); puzzle k relabels each given v to ((v-1+k) mod 4)+1.
    function automatic logic [ROW_W-1:0] rowWord(input logic [1:0] k, input logic [1:0] r);
        logic [15:0]      base;
        logic [3:0]       v;
        logic [1:0]       lbl;
        logic [ROW_W-1:0] w;
        w = '0;
        case (r)
            2'd0:    base = 16'h4001;
            2'd1:    base = 16'h0140;
            2'd2:    base = 16'h0410;
            default: base = 16'h1004;
        endcase
        for (int c = 0; c < 4; c++) begin
            v = base[4*c +: 4];
            if (v != 4'd0) begin
                lbl = v[1:0] - 2'd1 + k;
                w[5*c +: 5] = {1'b1, {2'b00, lbl} + 4'd1};
            end
        end
        return w;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            sel         <= 2'd0;
            row         <= 2'd0;
            waitCnt     <= 8'd0;
            RamAddr     <= '0;
            RamDat      <= '0;
            RamWriteBit <= 1'b0;
            portOwn     <= 1'b0;
            loadDone    <= 1'b0;
            loadError   <= 1'b0;
            retryCount  <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    sel         <= puzzleSel;
                    row         <= 2'd0;
                    state       <= WRITE;
                    RamAddr     <= '0;
                    RamDat      <= rowWord(puzzleSel, 2'd0);
                    RamWriteBit <= 1'b1;
                    portOwn     <= 1'b1;
                end
                WRITE: begin
                    if (row == 2'd3) begin
                        state       <= VADDR;
                        row         <= 2'd0;
                        RamAddr     <= '0;
                        RamDat      <= '0;
                        RamWriteBit <= 1'b0;
                    end else begin
                        row     <= row + 2'd1;
                        RamAddr <= ADDR_W'(row + 2'd1);
                        RamDat  <= rowWord(sel, row + 2'd1);
                    end
                end
                VADDR: begin
                    state   <= VWAIT;
                    waitCnt <= 8'd0;
                end
                VWAIT: begin
                    if (waitCnt != WAIT_LAST) begin
                        waitCnt <= waitCnt + 8'd1;
                    end else if (RamQ == rowWord(sel, row)) begin
                        if (row == 2'd3) begin
                            state    <= DONE;
                            RamAddr  <= '0;
                            portOwn  <= 1'b0;
                            loadDone <= 1'b1;
                        end else begin
                            row     <= row + 2'd1;
                            RamAddr <= ADDR_W'(row + 2'd1);
                            state   <= VADDR;
                        end
                    end else if (int'(retryCount) < MAX_RETRY) begin
                        // Full reload with the puzzle latched at load start.
                        retryCount  <= retryCount + 2'd1;
                        row         <= 2'd0;
                        state       <= WRITE;
                        RamAddr     <= '0;
                        RamDat      <= rowWord(sel, 2'd0);
                        RamWriteBit <= 1'b1;
                    end else begin
                        state     <= ERROR;
                        RamAddr   <= '0;
                        portOwn   <= 1'b0;
                        loadError <= 1'b1;
                    end
                end
                DONE, ERROR: begin
                    if (newGame) begin
                        sel         <= puzzleSel;
                        row         <= 2'd0;
                        retryCount  <= 2'd0;
                        loadDone    <= 1'b0;
                        loadError   <= 1'b0;
                        state       <= WRITE;
                        RamAddr     <= '0;
                        RamDat      <= rowWord(puzzleSel, 2'd0);
                        RamWriteBit <= 1'b1;
                        portOwn     <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
